// File: rtl/memory_lsu_if.sv
// Bundle of the execute, data-memory and writeback signals seen by the load/store stage.
// master is the surrounding pipeline/memory side; slave is the LSU itself.
interface memory_lsu_if;
    logic        ex_vld;
    logic        ex_rdy;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_res;
    logic [31:0] ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_wen;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        wb_vld;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;

    modport master (
        output ex_vld, ex_opcode, ex_funct3, ex_res, ex_rs2, ex_rd, ex_wen,
        input  ex_rdy,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  wb_vld, wb_wen, wb_rd, wb_data, wb_err
    );

    modport slave (
        input  ex_vld, ex_opcode, ex_funct3, ex_res, ex_rs2, ex_rd, ex_wen,
        output ex_rdy,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output wb_vld, wb_wen, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/memory_lsu.sv
// Load/store stage: registers one executed instruction, runs its data-memory access
// and hands a single aligned/extended result to writeback.
module memory_lsu (
    input  logic         clk,
    input  logic         rst,
    memory_lsu_if.slave  bus
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  a);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic        [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lane(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   return {4{rs2[7:0]}};
            2'b01:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    logic [1:0]  state_p0;
    logic [1:0]  state_nxt;

    logic [31:0] addr_p0;
    logic [2:0]  f3_p0;
    logic        store_p0;
    logic        err_p0;
    logic [4:0]  rd_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  wstrb_p0;
    logic        wen_p1;
    logic [31:0] data_p1;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        illegal;
    logic        misaligned;
    logic        err_c;
    logic        accept;

    assign is_load  = (bus.ex_opcode == OP_LOAD);
    assign is_store = (bus.ex_opcode == OP_STORE);
    assign is_mem   = is_load | is_store;

    // funct3[1:0] encodes the access size; the extension bit is irrelevant for alignment.
    assign illegal    = (is_load  & ((bus.ex_funct3 == 3'b011) | (bus.ex_funct3[2:1] == 2'b11)))
                      | (is_store & (bus.ex_funct3 >= 3'b011));
    assign misaligned = is_mem & (((bus.ex_funct3[1:0] == 2'b01) & bus.ex_res[0])
                                | ((bus.ex_funct3[1:0] == 2'b10) & (bus.ex_res[1:0] != 2'b00)));
    assign err_c      = illegal | misaligned;
    assign accept     = bus.ex_vld & (state_p0 == IDLE);

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE: if (accept) state_nxt = (is_mem && !err_c) ? REQ : DONE;
            REQ:  if (bus.mem_gnt) state_nxt = store_p0 ? DONE : WAIT;
            WAIT: if (bus.mem_rvalid) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_p0 <= IDLE;
        else     state_p0 <= state_nxt;
    end

    // ---- p0: instruction latched at accept ----
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= bus.ex_res;
            f3_p0    <= bus.ex_funct3;
            store_p0 <= is_store;
            err_p0   <= err_c;
            rd_p0    <= bus.ex_rd;
            wdata_p0 <= store_lane(bus.ex_funct3, bus.ex_rs2);
            wstrb_p0 <= store_strb(bus.ex_funct3, bus.ex_res[1:0]);
        end
    end

    // ---- p1: writeback result, filled at accept or on read return ----
    always_ff @(posedge clk) begin
        if (accept) begin
            wen_p1  <= bus.ex_wen & (bus.ex_rd != 5'd0) & ~is_store & ~err_c;
            data_p1 <= is_mem ? 32'd0 : bus.ex_res;
        end else if ((state_p0 == WAIT) && bus.mem_rvalid) begin
            data_p1 <= load_extend(bus.mem_rdata, f3_p0, addr_p0[1:0]);
        end
    end

    // Outputs are qualified by state, so the async state reset alone clears them.
    assign bus.ex_rdy    = (state_p0 == IDLE);
    assign bus.mem_req   = (state_p0 == REQ);
    assign bus.mem_we    = bus.mem_req & store_p0;
    assign bus.mem_addr  = bus.mem_req ? {addr_p0[31:2], 2'b00} : 32'd0;
    assign bus.mem_wdata = bus.mem_we ? wdata_p0 : 32'd0;
    assign bus.mem_wstrb = bus.mem_we ? wstrb_p0 : 4'd0;

    assign bus.wb_vld    = (state_p0 == DONE);
    assign bus.wb_wen    = bus.wb_vld & wen_p1;
    assign bus.wb_rd     = bus.wb_vld ? rd_p0 : 5'd0;
    assign bus.wb_data   = bus.wb_vld ? data_p1 : 32'd0;
    assign bus.wb_err    = bus.wb_vld & err_p0;

endmodule

// File: tb/tb_memory_lsu.sv
// Directed bench for memory_lsu: writeback results are scoreboarded at issue time
// and compared when wb_vld appears; memory responses are driven step by step.
module tb_memory_lsu;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_lsu_if bus();
    memory_lsu dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  acc_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_exp(input logic wen, input logic [4:0] rd,
                            input logic [31:0] data, input logic err);
        wb_t e;
        e.wen = wen; e.rd = rd; e.data = data; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic wen);
        bus.ex_vld = 1'b1; bus.ex_opcode = op; bus.ex_funct3 = f3;
        bus.ex_res = res; bus.ex_rs2 = rs2; bus.ex_rd = rd; bus.ex_wen = wen;
        chk("ex_rdy_before_issue", bus.ex_rdy, 1'b1);
        tick();
        bus.ex_vld = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_wb(input string tag, input int exp_lat);
        wb_t e;
        int  n = 0;
        while (bus.wb_vld !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.wb_vld !== 1'b1) begin
            chk({tag, "_timeout"}, bus.wb_vld, 1'b1);
            return;
        end
        chk({tag, "_latency"}, cyc - acc_cyc + 1, exp_lat);
        chk({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({tag, "_wb_wen"},  bus.wb_wen,  e.wen);
        chk({tag, "_wb_rd"},   bus.wb_rd,   e.rd);
        chk({tag, "_wb_data"}, bus.wb_data, e.data);
        chk({tag, "_wb_err"},  bus.wb_err,  e.err);
        tick();
        chk({tag, "_wb_pulse"}, bus.wb_vld, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.ex_vld = 0; bus.ex_opcode = 0; bus.ex_funct3 = 0; bus.ex_res = 0;
        bus.ex_rs2 = 0; bus.ex_rd = 0; bus.ex_wen = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        tick(); tick();
        chk("rst_ex_rdy",    bus.ex_rdy,    1'b1);
        chk("rst_mem_req",   bus.mem_req,   1'b0);
        chk("rst_mem_we",    bus.mem_we,    1'b0);
        chk("rst_mem_addr",  bus.mem_addr,  32'd0);
        chk("rst_mem_wstrb", bus.mem_wstrb, 4'd0);
        chk("rst_wb_vld",    bus.wb_vld,    1'b0);
        chk("rst_wb_data",   bus.wb_data,   32'd0);
        chk("rst_wb_err",    bus.wb_err,    1'b0);
        rst = 1'b0;
        tick();

        // ADD pass-through
        issue(OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        push_exp(1'b1, 5'd5, 32'h0000_1234, 1'b0);
        chk("add_ex_rdy_low", bus.ex_rdy, 1'b0);
        chk("add_no_req", bus.mem_req, 1'b0);
        wait_wb("add", 1);

        // LB sign extension, grant immediately, rvalid next cycle
        issue(OP_LOAD, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
        push_exp(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
        chk("lb_req",  bus.mem_req,  1'b1);
        chk("lb_we",   bus.mem_we,   1'b0);
        chk("lb_addr", bus.mem_addr, 32'h0000_0100);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        chk("lb_wait_no_req", bus.mem_req, 1'b0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h80AA_BBCC;
        tick();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        wait_wb("lb", 3);

        // LHU zero extension with one rvalid stall cycle
        issue(OP_LOAD, 3'b101, 32'h0000_0202, 32'h0, 5'd8, 1'b1);
        push_exp(1'b1, 5'd8, 32'h0000_9876, 1'b0);
        chk("lhu_addr", bus.mem_addr, 32'h0000_0200);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        tick();
        chk("lhu_stall_no_wb", bus.wb_vld, 1'b0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h9876_5432;
        tick();
        bus.mem_rvalid = 1'b0;
        wait_wb("lhu", 4);

        // SH with grant held low three cycles
        issue(OP_STORE, 3'b001, 32'h0000_0302, 32'hDEAD_BEEF, 5'd9, 1'b1);
        push_exp(1'b0, 5'd9, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("sh_req",   bus.mem_req,   1'b1);
            chk("sh_we",    bus.mem_we,    1'b1);
            chk("sh_addr",  bus.mem_addr,  32'h0000_0300);
            chk("sh_wstrb", bus.mem_wstrb, 4'b1100);
            chk("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
            if (i == 3) bus.mem_gnt = 1'b1;
            tick();
        end
        bus.mem_gnt = 1'b0;
        wait_wb("sh", 5);

        // SB to lane 1
        issue(OP_STORE, 3'b000, 32'h0000_0411, 32'h1234_56A5, 5'd0, 1'b0);
        push_exp(1'b0, 5'd0, 32'h0, 1'b0);
        chk("sb_addr",  bus.mem_addr,  32'h0000_0410);
        chk("sb_wstrb", bus.mem_wstrb, 4'b0010);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        wait_wb("sb", 2);

        // SW
        issue(OP_STORE, 3'b010, 32'h0000_0800, 32'hCAFE_F00D, 5'd0, 1'b0);
        push_exp(1'b0, 5'd0, 32'h0, 1'b0);
        chk("sw_wstrb", bus.mem_wstrb, 4'b1111);
        chk("sw_wdata", bus.mem_wdata, 32'hCAFE_F00D);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        wait_wb("sw", 2);

        // Misaligned LW: no request, immediate error retire
        issue(OP_LOAD, 3'b010, 32'h0000_0401, 32'h0, 5'd4, 1'b1);
        push_exp(1'b0, 5'd4, 32'h0, 1'b1);
        chk("mis_lw_no_req", bus.mem_req, 1'b0);
        wait_wb("mis_lw", 1);

        // Misaligned LH
        issue(OP_LOAD, 3'b001, 32'h0000_0403, 32'h0, 5'd4, 1'b1);
        push_exp(1'b0, 5'd4, 32'h0, 1'b1);
        wait_wb("mis_lh", 1);

        // Illegal store funct3 011 and illegal load funct3 110
        issue(OP_STORE, 3'b011, 32'h0000_0500, 32'h1111_2222, 5'd6, 1'b1);
        push_exp(1'b0, 5'd6, 32'h0, 1'b1);
        chk("ill_st_no_req", bus.mem_req, 1'b0);
        wait_wb("ill_st", 1);
        issue(OP_LOAD, 3'b110, 32'h0000_0500, 32'h0, 5'd6, 1'b1);
        push_exp(1'b0, 5'd6, 32'h0, 1'b1);
        wait_wb("ill_ld", 1);

        // LW to rd=0; rvalid alongside gnt in REQ must be ignored
        issue(OP_LOAD, 3'b010, 32'h0000_0700, 32'h0, 5'd0, 1'b1);
        push_exp(1'b0, 5'd0, 32'h1234_5678, 1'b0);
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        tick();
        chk("lw_rd0_still_waiting", bus.wb_vld, 1'b0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_rvalid = 1'b0;
        wait_wb("lw_rd0", 4);

        // Stray rvalid while idle has no effect
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("idle_rvalid_no_wb", bus.wb_vld, 1'b0);

        // Reset during REQ drops the request asynchronously
        issue(OP_LOAD, 3'b010, 32'h0000_0600, 32'h0, 5'd3, 1'b1);
        chk("rreq_req_before", bus.mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rreq_req_async", bus.mem_req, 1'b0);
        chk("rreq_ex_rdy",    bus.ex_rdy,  1'b1);
        tick();
        rst = 1'b0;
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        chk("rreq_gnt_no_req", bus.mem_req, 1'b0);
        chk("rreq_gnt_no_wb",  bus.wb_vld,  1'b0);

        // Reset during WAIT, then a stray rvalid
        issue(OP_LOAD, 3'b010, 32'h0000_0500, 32'h0, 5'd3, 1'b1);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        chk("rwait_in_wait", bus.ex_rdy, 1'b0);
        rst = 1'b1;
        #1;
        chk("rwait_ex_rdy",  bus.ex_rdy,  1'b1);
        chk("rwait_mem_req", bus.mem_req, 1'b0);
        chk("rwait_wb_vld",  bus.wb_vld,  1'b0);
        tick();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("rwait_stray_no_wb", bus.wb_vld, 1'b0);
        tick();
        chk("rwait_stray_no_wb2", bus.wb_vld, 1'b0);
        chk("rwait_ex_rdy_after", bus.ex_rdy, 1'b1);

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_lsu.md
# memory_lsu

Load/store stage sitting directly downstream of the execute ALU. It registers each executed instruction, turns the ALU result into a data-memory access for loads and stores, and aligns/extends load data. It forwards one result per instruction to writeback; non-memory results pass through with one cycle of latency.

## Interface
Parameters:
- none; widths are fixed at 32-bit data and address, with a 5-bit register index.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_vld`  in  1  execute holds a valid instruction.
- `ex_rdy`  out  1  stage can accept; `ex_rdy` = (state==IDLE).
- `ex_opcode`  in  7  instruction opcode; uses `OP_LOAD`/`OP_STORE` from `utils_top`.
- `ex_funct3`  in  3  access size and sign.
- `ex_res`  in  32  ALU output: the address for loads/stores, otherwise the result.
- `ex_rs2`  in  32  store data.
- `ex_rd`  in  5  destination register.
- `ex_wen`  in  1  instruction writes rd (ignored for stores).
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  32  word-aligned address {addr[31:2],2'b00}.
- `mem_wdata`  out  32  store data shifted to its byte lane.
- `mem_wstrb`  out  4  byte enables.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.
- `wb_vld`  out  1  one-cycle pulse: instruction retired.
- `wb_wen`  out  1  write rd.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  writeback value.
- `wb_err`  out  1  misaligned or illegal access.

## Operation
- Accept occurs when `ex_vld & ex_rdy`. The stage latches opcode, funct3, res, rs2, rd and wen.
- FSM states are IDLE, REQ, WAIT and DONE.
- **IDLE:**
  - Non-memory op: go to DONE with `wb_data`=res.
  - Legal load/store: go to REQ.
  - Illegal or misaligned access: go to DONE with err=1.
- **REQ:**
  - `mem_req`=1; addr, we, wdata and wstrb are held stable until `mem_gnt`.
  - Store with gnt: go to DONE.
  - Load with gnt: go to WAIT.
- **WAIT:** on `mem_rvalid`, capture the extracted data and go to DONE.
- **DONE:** `wb_vld`=1 for one cycle, then go to IDLE.
- **Legal loads:**
  - LB 000 and LBU 100 take byte `rdata[8*a[1:0]+:8]`.
  - LH 001 and LHU 101 take half `rdata[16*a[1]+:16]`.
  - LW 010 takes the full word.
  - Sign-extend for funct3[2]=0; zero-extend for funct3[2]=1.
- **Legal stores:**
  - SB 000: wstrb=0001<<a[1:0], wdata={4{rs2[7:0]}}.
  - SH 001: wstrb=0011<<{a[1],1'b0}, wdata={2{rs2[15:0]}}.
  - SW 010: wstrb=1111, wdata=rs2.
- **Errors:**
  - Misaligned means a half access with a[0]=1 or a word access with a[1:0]≠0.
  - Illegal means any load funct3 in {011,110,111} or any store funct3 ≥011.
  - Neither issues a memory request; the instruction retires with `wb_err`=1 and `wb_wen`=0.
- **wb_wen:**
  - Equals latched wen & (rd≠0) for loads and non-memory ops.
  - Is 0 for stores and errors.
- **wb_data:** 0 for stores and errors.
- **mem_rvalid:** ignored outside WAIT.
- **Reset values:** every output is 0 while `rst` is high, except `ex_rdy`=1. State returns to IDLE.
- **Reset mid-REQ/WAIT:** the request drops immediately (asynchronously) and the instruction is discarded with no `wb_vld`.
- **Post-reset stragglers:** `mem_gnt`/`mem_rvalid` arriving in IDLE after reset have no effect.

## Timing
- Non-memory or error op accepted at edge T: `wb_vld` high in cycle T+1; `ex_rdy` low for that cycle, so throughput is 1 instruction per 2 cycles.
- Load accepted at T: `mem_req` in cycle T+1.
  - With gnt at T+1 and rvalid at T+2, `wb_vld` is at T+3.
  - Each stall cycle of gnt or rvalid adds one cycle.
- Store accepted at T: with gnt at T+1, `wb_vld` is at T+2.
- `mem_req` depends only on state (registered): no combinational path from `mem_gnt` or `ex_vld` to any output.
- `ex_rdy` is a function of state only.
- `mem_gnt` and `mem_rvalid` in the same cycle while in REQ: rvalid is ignored. Memory must deliver rvalid in a cycle after gnt.

## Test plan
- **ADD pass-through:** opcode 0110011, res=0x0000_1234, rd=5, wen=1 -> one cycle later wb_vld=1, wb_data=0x1234, wb_rd=5, wb_wen=1.
- **LB sign extension:** res=0x103, rdata=0x80AA_BBCC, gnt immediately, rvalid next -> mem_addr=0x100, wb_data=0xFFFF_FF80, wb_vld 3 cycles after accept.
- **LHU zero extension:** res=0x202, rdata=0x9876_5432 -> wb_data=0x0000_9876.
- **SH with stall:** SH res=0x302, rs2=0xDEAD_BEEF, gnt held low 3 cycles -> mem_req, addr 0x300, wstrb 1100 and wdata 0xBEEF_BEEF held stable throughout; wb_vld with wb_wen=0 one cycle after gnt.
- **Misaligned LW:** res=0x401 -> no mem_req; next cycle wb_vld=1, wb_err=1, wb_wen=0. Also a load with rd=0 -> wb_wen=0.
- **Reset in WAIT:** assert rst while in WAIT, then a stray rvalid after release -> mem_req=0 and no wb_vld; ex_rdy=1 immediately after reset.
